// File: rtl/regfile_dual.sv
// rtl/regfile_dual.sv - dual-issue GPR file with HI/LO and writeback bypass
// Slot 2 is the younger instruction, so it wins every same-cycle conflict.
module regfile_dual (
   input  logic         clk,
   input  logic         rst,
   input  logic [207:0] wb_to_rf_bus,
   input  logic [4:0]   raddr1,
   input  logic [4:0]   raddr2,
   input  logic [4:0]   raddr3,
   input  logic [4:0]   raddr4,
   output logic [31:0]  rdata1,
   output logic [31:0]  rdata2,
   output logic [31:0]  rdata3,
   output logic [31:0]  rdata4,
   output logic [31:0]  hi_rdata,
   output logic [31:0]  lo_rdata
);

   logic [65:0] hilo_i1, hilo_i2;
   logic        we_i1, we_i2;
   logic [4:0]  waddr_i1, waddr_i2;
   logic [31:0] wdata_i1, wdata_i2;

   assign {hilo_i2, we_i2, waddr_i2, wdata_i2,
           hilo_i1, we_i1, waddr_i1, wdata_i1} = wb_to_rf_bus;

   logic        hi_we_i1, lo_we_i1, hi_we_i2, lo_we_i2;
   logic [31:0] hi_wdata_i1, lo_wdata_i1, hi_wdata_i2, lo_wdata_i2;

   assign {hi_we_i1, lo_we_i1, hi_wdata_i1, lo_wdata_i1} = hilo_i1;
   assign {hi_we_i2, lo_we_i2, hi_wdata_i2, lo_wdata_i2} = hilo_i2;

   // $0 has no storage; index 0 is never built
   logic [31:0] gpr_q [1:31];
   logic [31:0] gpr_d [1:31];
   logic [31:0] hi_q, hi_d, lo_q, lo_d;

   always_comb begin
      for (int i = 1; i < 32; i++) begin
         gpr_d[i] = gpr_q[i];
         if (we_i1 && waddr_i1 == 5'(i)) gpr_d[i] = wdata_i1;
         if (we_i2 && waddr_i2 == 5'(i)) gpr_d[i] = wdata_i2;
         if (rst) gpr_d[i] = '0;
      end
   end

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (hi_we_i1) hi_d = hi_wdata_i1;
      if (lo_we_i1) lo_d = lo_wdata_i1;
      if (hi_we_i2) hi_d = hi_wdata_i2;
      if (lo_we_i2) lo_d = lo_wdata_i2;
      if (rst) begin
         hi_d = '0;
         lo_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 1; i < 32; i++) begin
         gpr_q[i] <= gpr_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
   end

   // Bypass is independent of rst so a write in the reset cycle is still visible
   function automatic logic [31:0] read_gpr(input logic [4:0] a);
      if (a == 5'd0)                       return 32'd0;
      else if (we_i2 && waddr_i2 == a)     return wdata_i2;
      else if (we_i1 && waddr_i1 == a)     return wdata_i1;
      else                                 return gpr_q[a];
   endfunction

   always_comb begin
      rdata1 = read_gpr(raddr1);
      rdata2 = read_gpr(raddr2);
      rdata3 = read_gpr(raddr3);
      rdata4 = read_gpr(raddr4);
   end

   always_comb begin
      hi_rdata = hi_q;
      lo_rdata = lo_q;
      if (hi_we_i2)      hi_rdata = hi_wdata_i2;
      else if (hi_we_i1) hi_rdata = hi_wdata_i1;
      if (lo_we_i2)      lo_rdata = lo_wdata_i2;
      else if (lo_we_i1) lo_rdata = lo_wdata_i1;
   end

endmodule

// File: tb/tb_regfile_dual.sv
// tb/tb_regfile_dual.sv - randomized self-checking bench for regfile_dual
// Reference model: array of registers updated in program order each edge.
module tb_regfile_dual;

   logic         clk = 1'b0;
   logic         rst;
   logic [207:0] wb_to_rf_bus;
   logic [4:0]   raddr1, raddr2, raddr3, raddr4;
   logic [31:0]  rdata1, rdata2, rdata3, rdata4, hi_rdata, lo_rdata;

   logic [31:0] wd1, wd2;
   logic [4:0]  wa1, wa2;
   logic        we1, we2;
   logic [65:0] hl1, hl2;

   assign wb_to_rf_bus = {hl2, we2, wa2, wd2, hl1, we1, wa1, wd1};

   int checks = 0;
   int failures = 0;

   logic [31:0] m_gpr [0:31];
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   regfile_dual dut (
      .clk(clk), .rst(rst), .wb_to_rf_bus(wb_to_rf_bus),
      .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3), .raddr4(raddr4),
      .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3), .rdata4(rdata4),
      .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
   );

   // Expected read: the latest matching write of this cycle, else storage
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] r;
      if (a == 5'd0) return 32'd0;
      r = m_gpr[a];
      if (we1 && wa1 == a) r = wd1;
      if (we2 && wa2 == a) r = wd2;
      return r;
   endfunction

   function automatic logic [31:0] exp_hi();
      logic [31:0] r;
      r = m_hi;
      if (hl1[65]) r = hl1[63:32];
      if (hl2[65]) r = hl2[63:32];
      return r;
   endfunction

   function automatic logic [31:0] exp_lo();
      logic [31:0] r;
      r = m_lo;
      if (hl1[64]) r = hl1[31:0];
      if (hl2[64]) r = hl2[31:0];
      return r;
   endfunction

   task automatic idle();
      wd1 = '0; wd2 = '0; wa1 = '0; wa2 = '0;
      we1 = 1'b0; we2 = 1'b0; hl1 = '0; hl2 = '0;
   endtask

   // Advance one edge and mirror it in the model, then return to the falling edge
   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
         m_hi = 32'd0;
         m_lo = 32'd0;
      end else begin
         if (we1 && wa1 != 5'd0) m_gpr[wa1] = wd1;
         if (we2 && wa2 != 5'd0) m_gpr[wa2] = wd2;
         if (hl1[65]) m_hi = hl1[63:32];
         if (hl1[64]) m_lo = hl1[31:0];
         if (hl2[65]) m_hi = hl2[63:32];
         if (hl2[64]) m_lo = hl2[31:0];
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      raddr1 = 5'd1; raddr2 = 5'd2; raddr3 = 5'd31; raddr4 = 5'd0;
      step();
      step();
      rst = 1'b0;
      #1;
      checks += 6;
      if (rdata1 !== 32'd0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'd0); end
      if (rdata2 !== 32'd0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=%h", rdata2, 32'd0); end
      if (rdata3 !== 32'd0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=%h", rdata3, 32'd0); end
      if (rdata4 !== 32'd0) begin failures++; $display("FAIL reset_rdata4 got=%h exp=%h", rdata4, 32'd0); end
      if (hi_rdata !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_rdata, 32'd0); end
      if (lo_rdata !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_rdata, 32'd0); end
   endtask

   task automatic test_dual_write();
      idle();
      we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h12345678;
      we2 = 1'b1; wa2 = 5'd6; wd2 = 32'hCAFEF00D;
      raddr1 = 5'd5; raddr3 = 5'd6;
      #1;
      checks += 2;
      if (rdata1 !== 32'h12345678) begin failures++; $display("FAIL dual_bypass_r1 got=%h exp=%h", rdata1, 32'h12345678); end
      if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL dual_bypass_r3 got=%h exp=%h", rdata3, 32'hCAFEF00D); end
      step();
      idle();
      #1;
      checks += 2;
      if (rdata1 !== 32'h12345678) begin failures++; $display("FAIL dual_stored_r1 got=%h exp=%h", rdata1, 32'h12345678); end
      if (rdata3 !== 32'hCAFEF00D) begin failures++; $display("FAIL dual_stored_r3 got=%h exp=%h", rdata3, 32'hCAFEF00D); end
   endtask

   task automatic test_same_addr();
      idle();
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h11111111;
      we2 = 1'b1; wa2 = 5'd7; wd2 = 32'h22222222;
      raddr2 = 5'd7; raddr4 = 5'd7;
      #1;
      checks += 2;
      if (rdata2 !== 32'h22222222) begin failures++; $display("FAIL same_bypass_r2 got=%h exp=%h", rdata2, 32'h22222222); end
      if (rdata4 !== 32'h22222222) begin failures++; $display("FAIL same_bypass_r4 got=%h exp=%h", rdata4, 32'h22222222); end
      step();
      idle();
      #1;
      checks++;
      if (rdata2 !== 32'h22222222) begin failures++; $display("FAIL same_stored_r2 got=%h exp=%h", rdata2, 32'h22222222); end
   endtask

   task automatic test_zero_write();
      idle();
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
      raddr2 = 5'd0;
      #1;
      checks++;
      if (rdata2 !== 32'd0) begin failures++; $display("FAIL zero_bypass got=%h exp=%h", rdata2, 32'd0); end
      step();
      idle();
      #1;
      checks++;
      if (rdata2 !== 32'd0) begin failures++; $display("FAIL zero_stored got=%h exp=%h", rdata2, 32'd0); end
   endtask

   task automatic test_hilo_split();
      idle();
      hl1 = {1'b1, 1'b1, 32'hAAAA0000, 32'hBBBB0000};
      hl2 = {1'b0, 1'b1, 32'h5A5A5A5A, 32'hCCCC0000};
      #1;
      checks += 2;
      if (hi_rdata !== 32'hAAAA0000) begin failures++; $display("FAIL hilo_bypass_hi got=%h exp=%h", hi_rdata, 32'hAAAA0000); end
      if (lo_rdata !== 32'hCCCC0000) begin failures++; $display("FAIL hilo_bypass_lo got=%h exp=%h", lo_rdata, 32'hCCCC0000); end
      step();
      idle();
      #1;
      checks += 2;
      if (hi_rdata !== 32'hAAAA0000) begin failures++; $display("FAIL hilo_stored_hi got=%h exp=%h", hi_rdata, 32'hAAAA0000); end
      if (lo_rdata !== 32'hCCCC0000) begin failures++; $display("FAIL hilo_stored_lo got=%h exp=%h", lo_rdata, 32'hCCCC0000); end
   endtask

   task automatic test_reset_mid_write();
      idle();
      rst = 1'b1;
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5;
      raddr1 = 5'd3; raddr2 = 5'd5;
      #1;
      checks++;
      if (rdata1 !== 32'h5) begin failures++; $display("FAIL rst_bypass got=%h exp=%h", rdata1, 32'h5); end
      step();
      rst = 1'b0;
      idle();
      #1;
      checks += 2;
      if (rdata1 !== 32'd0) begin failures++; $display("FAIL rst_lost_write got=%h exp=%h", rdata1, 32'd0); end
      if (rdata2 !== 32'd0) begin failures++; $display("FAIL rst_cleared_r5 got=%h exp=%h", rdata2, 32'd0); end
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5;
      step();
      idle();
      #1;
      checks++;
      if (rdata1 !== 32'h5) begin failures++; $display("FAIL rst_rewrite got=%h exp=%h", rdata1, 32'h5); end
   endtask

   task automatic test_random();
      logic [31:0] e;
      for (int n = 0; n < 400; n++) begin
         idle();
         rst = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 5) != 0) begin
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            we2 = 1'($urandom); wa2 = 5'($urandom_range(0, 7)); wd2 = $urandom;
            hl1 = {2'($urandom), 32'($urandom), 32'($urandom)};
            hl2 = {2'($urandom), 32'($urandom), 32'($urandom)};
         end
         raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 7));
         raddr3 = 5'($urandom_range(0, 7)); raddr4 = 5'($urandom);
         #1;
         checks += 6;
         e = exp_rd(raddr1);
         if (rdata1 !== e) begin failures++; $display("FAIL rand_r1 n=%0d got=%h exp=%h", n, rdata1, e); end
         e = exp_rd(raddr2);
         if (rdata2 !== e) begin failures++; $display("FAIL rand_r2 n=%0d got=%h exp=%h", n, rdata2, e); end
         e = exp_rd(raddr3);
         if (rdata3 !== e) begin failures++; $display("FAIL rand_r3 n=%0d got=%h exp=%h", n, rdata3, e); end
         e = exp_rd(raddr4);
         if (rdata4 !== e) begin failures++; $display("FAIL rand_r4 n=%0d got=%h exp=%h", n, rdata4, e); end
         e = exp_hi();
         if (hi_rdata !== e) begin failures++; $display("FAIL rand_hi n=%0d got=%h exp=%h", n, hi_rdata, e); end
         e = exp_lo();
         if (lo_rdata !== e) begin failures++; $display("FAIL rand_lo n=%0d got=%h exp=%h", n, lo_rdata, e); end
         step();
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      raddr1 = '0; raddr2 = '0; raddr3 = '0; raddr4 = '0;
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      test_reset();
      test_dual_write();
      test_same_addr();
      test_zero_write();
      test_hilo_split();
      test_reset_mid_write();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
